pulser_bank: RTL and testbench

PULSER_BANK -- requirements
Module: pulser_bank

---
 rtl/pulser_pkg.sv | 22 ++
 rtl/pulser_channel.sv | 124 ++++++++++++
 rtl/pulser_bank.sv | 33 +++
 tb/tb_pulser_bank.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pulser_pkg.sv
// Shared definitions for the push-button pulser: per-channel FSM state encoding
// and the counter sizing rule used by every channel.
package pulser_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE        = 3'd0;
    localparam state_t ST_DEB_PRESS   = 3'd1;
    localparam state_t ST_PULSE       = 3'd2;
    localparam state_t ST_HELD        = 3'd3;
    localparam state_t ST_DEB_RELEASE = 3'd4;

    // One counter serves debounce and repeat timing, so it is sized for the largest of the three.
    function automatic int cnt_width(input int debounce, input int rpt_delay, input int rpt_period);
        int m;
        m = debounce;
        if (rpt_delay > m) m = rpt_delay;
        if (rpt_period > m) m = rpt_period;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/pulser_channel.sv
// One push-button channel: 2-flop synchroniser, debounce/auto-repeat FSM and
// a single saturating counter, with registered pulse and held outputs.
module pulser_channel
    import pulser_pkg::*;
#(
    parameter int DEBOUNCE      = 4,
    parameter int REPEAT_EN     = 0,
    parameter int REPEAT_DELAY  = 16,
    parameter int REPEAT_PERIOD = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic pulse,
    output logic held
);

    localparam int CW = cnt_width(DEBOUNCE, REPEAT_DELAY, REPEAT_PERIOD);

    localparam logic [CW-1:0] CNT_ZERO = '0;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [CW-1:0] DEB_CNT  = CW'(DEBOUNCE);
    // HELD is entered one cycle after the initial pulse and the pulse itself is registered,
    // hence DELAY-2 for the first repeat; later repeats restart from zero in the pulse cycle.
    localparam logic [CW-1:0] DLY_CNT  = CW'(REPEAT_DELAY - 2);
    localparam logic [CW-1:0] PER_CNT  = CW'(REPEAT_PERIOD - 1);

    logic          sync1_q, sync2_q;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rpt_q, rpt_d;
    logic          pulse_q, pulse_d;
    logic          held_q, held_d;
    logic [CW-1:0] cnt_inc;

    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    // NOTE: every always_comb output gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rpt_d   = rpt_q;
        pulse_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = sync2_q ? CNT_ONE : CNT_ZERO;
                if (sync2_q) state_d = ST_DEB_PRESS;
            end
            ST_DEB_PRESS: begin
                if (!sync2_q) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == DEB_CNT) begin
                    state_d = ST_PULSE;
                    cnt_d   = CNT_ZERO;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_PULSE: begin
                state_d = ST_HELD;
                cnt_d   = CNT_ZERO;
                rpt_d   = 1'b0;
            end
            ST_HELD: begin
                if (!sync2_q) begin
                    state_d = ST_DEB_RELEASE;
                    cnt_d   = CNT_ONE;
                end else if ((REPEAT_EN != 0) && (cnt_q == (rpt_q ? PER_CNT : DLY_CNT))) begin
                    pulse_d = 1'b1;
                    cnt_d   = CNT_ZERO;
                    rpt_d   = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_DEB_RELEASE: begin
                if (sync2_q) begin
                    state_d = ST_HELD;
                    cnt_d   = CNT_ZERO;
                    rpt_d   = 1'b0;
                end else if (cnt_q == DEB_CNT) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
                rpt_d   = 1'b0;
            end
        endcase
        held_d = (state_d == ST_PULSE) || (state_d == ST_HELD) || (state_d == ST_DEB_RELEASE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            rpt_q   <= 1'b0;
            pulse_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rpt_q   <= rpt_d;
            pulse_q <= pulse_d;
            held_q  <= held_d;
        end
    end

    assign pulse = pulse_q;
    assign held  = held_q;

endmodule

// File: rtl/pulser_bank.sv
// Bank of independent debounced push-button pulsers, one pulser_channel per bit.
module pulser_bank
    import pulser_pkg::*;
#(
    parameter int CHANNELS      = 4,
    parameter int DEBOUNCE      = 4,
    parameter int REPEAT_EN     = 0,
    parameter int REPEAT_DELAY  = 16,
    parameter int REPEAT_PERIOD = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] btn_in,
    output logic [CHANNELS-1:0] pulse,
    output logic [CHANNELS-1:0] held
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        pulser_channel #(
            .DEBOUNCE      (DEBOUNCE),
            .REPEAT_EN     (REPEAT_EN),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
        ) u_ch (
            .clk    (clk),
            .reset  (reset),
            .btn_in (btn_in[i]),
            .pulse  (pulse[i]),
            .held   (held[i])
        );
    end

endmodule

// File: tb/tb_pulser_bank.sv
// Randomised + directed bench for pulser_bank: two instances (no repeat / repeat),
// a run-length reference model feeding a scoreboard queue, and a decoupled monitor.
module tb_pulser_bank;

    localparam int CH  = 4;
    localparam int DEB = 4;
    localparam int DLY = 16;
    localparam int PER = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [CH-1:0] btn;
    logic [CH-1:0] pulse_a, held_a, pulse_b, held_b;

    int n_cmp = 0;
    int n_bad = 0;
    int edge_n = 0;

    always #5 clk = ~clk;

    pulser_bank #(.CHANNELS(CH), .DEBOUNCE(DEB), .REPEAT_EN(0), .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER))
    u_dut_a (.clk(clk), .reset(reset), .btn_in(btn), .pulse(pulse_a), .held(held_a));

    pulser_bank #(.CHANNELS(CH), .DEBOUNCE(DEB), .REPEAT_EN(1), .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER))
    u_dut_b (.clk(clk), .reset(reset), .btn_in(btn), .pulse(pulse_b), .held(held_b));

    typedef struct {
        int            edge_n;
        logic [CH-1:0] pa, ha, pb, hb;
    } exp_t;

    exp_t sb_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, got, exp);
        end
    endtask

    // Reference model: a press is accepted after DEB+1 consecutive high synchronised samples,
    // the sample right after acceptance is ignored, a release after DEB+1 consecutive lows.
    // Repeats are scheduled on absolute edge numbers.
    logic [CH-1:0] m_d1, m_d2;
    bit            m_acc [2][CH];
    bit            m_skip[2][CH];
    int            m_run [2][CH];
    int            m_next[2][CH];

    task automatic model_step(input logic rst_v, input logic [CH-1:0] b, input int n);
        exp_t          e;
        logic [CH-1:0] s;
        logic [CH-1:0] ep[2];
        logic [CH-1:0] eh[2];
        ep[0] = '0; ep[1] = '0; eh[0] = '0; eh[1] = '0;
        if (rst_v) begin
            m_d1 = '0;
            m_d2 = '0;
            for (int k = 0; k < 2; k++)
                for (int c = 0; c < CH; c++) begin
                    m_acc[k][c] = 0; m_skip[k][c] = 0; m_run[k][c] = 0; m_next[k][c] = 0;
                end
        end else begin
            s    = m_d2;
            m_d2 = m_d1;
            m_d1 = b;
            for (int k = 0; k < 2; k++) begin
                for (int c = 0; c < CH; c++) begin
                    if (m_skip[k][c]) begin
                        m_skip[k][c] = 0;
                    end else if (!m_acc[k][c]) begin
                        if (s[c]) begin
                            m_run[k][c]++;
                            if (m_run[k][c] == DEB + 1) begin
                                m_acc[k][c]  = 1;
                                m_run[k][c]  = 0;
                                m_skip[k][c] = 1;
                                ep[k][c]     = 1'b1;
                                m_next[k][c] = n + DLY;
                            end
                        end else begin
                            m_run[k][c] = 0;
                        end
                    end else if (!s[c]) begin
                        m_run[k][c]++;
                        if (m_run[k][c] == DEB + 1) begin
                            m_acc[k][c] = 0;
                            m_run[k][c] = 0;
                        end
                    end else if (m_run[k][c] > 0) begin
                        m_run[k][c]  = 0;
                        m_next[k][c] = n - 1 + DLY;
                    end else if (k == 1 && n == m_next[k][c]) begin
                        ep[k][c]     = 1'b1;
                        m_next[k][c] = n + PER;
                    end
                    eh[k][c] = m_acc[k][c];
                end
            end
        end
        e.edge_n = n;
        e.pa = ep[0]; e.ha = eh[0]; e.pb = ep[1]; e.hb = eh[1];
        sb_q.push_back(e);
    endtask

    task automatic cycle();
        model_step(reset, btn, edge_n);
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic wait_pulse(input int inst, input int ch, input int bound, output int lat);
        lat = -1;
        for (int i = 0; i < bound; i++) begin
            cycle();
            if ((inst == 0) ? pulse_a[ch] : pulse_b[ch]) begin
                lat = i;
                break;
            end
        end
    endtask

    // Monitor: every cycle the DUTs present pulse/held; compare against the queued prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check($sformatf("pulse_a @edge %0d", e.edge_n), 32'(pulse_a), 32'(e.pa));
                check($sformatf("held_a @edge %0d", e.edge_n), 32'(held_a), 32'(e.ha));
                check($sformatf("pulse_b @edge %0d", e.edge_n), 32'(pulse_b), 32'(e.pb));
                check($sformatf("held_b @edge %0d", e.edge_n), 32'(held_b), 32'(e.hb));
            end
        end
    end

    initial begin
        int lat;
        int seen;
        int idx;
        int na;
        int np;
        int hall;
        int rep_exp[7];
        rep_exp = '{0, 16, 24, 32, 40, 48, 56};

        reset = 1'b1;
        btn   = '0;
        repeat (2) cycle();
        check("reset pulse_a", 32'(pulse_a), 0);
        check("reset held_b", 32'(held_b), 0);
        reset = 1'b0;
        repeat (4) cycle();

        // Single press: pulse exactly DEB+2 edges after the first edge that sees it.
        btn[0] = 1'b1;
        wait_pulse(0, 0, 30, lat);
        check("press latency ch0", lat, DEB + 2);
        cycle();
        check("ch0 pulse lasts one cycle", 32'(pulse_a[0]), 0);
        check("ch0 held after press", 32'(held_a[0]), 1);

        // Press shorter than the debounce window is rejected.
        btn[1] = 1'b1;
        seen = 0;
        repeat (3) begin cycle(); seen |= int'(pulse_a[1] | held_a[1]); end
        btn[1] = 1'b0;
        repeat (12) begin cycle(); seen |= int'(pulse_a[1] | held_a[1]); end
        check("short press ch1 ignored", seen, 0);

        // Long hold: repeat schedule on instance b, single pulse on instance a.
        btn[2] = 1'b1;
        wait_pulse(1, 2, 30, lat);
        check("press latency ch2", lat, DEB + 2);
        idx = 1;
        na  = int'(pulse_a[2]);
        for (int off = 1; off < 60; off++) begin
            cycle();
            na += int'(pulse_a[2]);
            if (pulse_b[2]) begin
                if (idx < 7) check($sformatf("repeat %0d offset", idx), off, rep_exp[idx]);
                else check("unexpected extra repeat", off, -1);
                idx++;
            end
        end
        check("repeat pulse count ch2", idx, 7);
        check("single pulse without repeat ch2", na, 1);
        btn[0] = 1'b0;
        btn[2] = 1'b0;

        // Held button with a 2-cycle low glitch: no extra pulse, held stays high.
        btn[3] = 1'b1;
        wait_pulse(0, 3, 30, lat);
        check("press latency ch3", lat, DEB + 2);
        repeat (5) cycle();
        np   = 0;
        hall = 1;
        btn[3] = 1'b0;
        repeat (2) begin cycle(); np += int'(pulse_a[3]); hall &= int'(held_a[3]); end
        btn[3] = 1'b1;
        repeat (20) begin cycle(); np += int'(pulse_a[3]); hall &= int'(held_a[3]); end
        check("glitch gives no pulse ch3", np, 0);
        check("glitch keeps held ch3", hall, 1);

        // Reset while held with the button still high: fresh press with full latency.
        reset = 1'b1;
        cycle();
        check("reset mid-hold pulse_a", 32'(pulse_a), 0);
        check("reset mid-hold held_a", 32'(held_a), 0);
        reset = 1'b0;
        wait_pulse(0, 3, 30, lat);
        check("post-reset latency ch3", lat, DEB + 2);

        // Simultaneous press on two channels.
        btn = '0;
        repeat (20) cycle();
        btn = 4'b1001;
        wait_pulse(0, 0, 30, lat);
        check("simultaneous latency", lat, DEB + 2);
        check("simultaneous pulse vector", 32'(pulse_a), 32'h9);
        btn = '0;
        repeat (10) cycle();

        // Randomised traffic, short toggles then long holds, rare resets.
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < CH; c++)
                if ($urandom_range(0, (i < 1500) ? 5 : 24) == 0) btn[c] = ~btn[c];
            reset = ($urandom_range(0, 499) == 0);
            cycle();
        end
        reset = 1'b0;
        btn   = '0;
        repeat (10) cycle();

        repeat (3) @(negedge clk);
        if (sb_q.size() != 0) check("scoreboard drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
